// File: rtl/ex_mem_stage_pkg.sv
// Shared RV32 execute-stage encodings: ALU ops, instruction classes,
// forwarding selects and branch conditions.
package rv_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_LUI   = 4'b1010;
  localparam logic [3:0] ALU_AUIPC = 4'b1011;

  localparam logic [1:0] ALUT_RI = 2'b00;
  localparam logic [1:0] ALUT_S  = 2'b01;
  localparam logic [1:0] ALUT_B  = 2'b10;
  localparam logic [1:0] ALUT_J  = 2'b11;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX inputs, fetch redirect and EX/MEM outputs of the execute stage.
interface ex_mem_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [4:0]      RdE;
  logic [3:0]      ALUControlE;
  logic            ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, JumpRE;
  logic [1:0]      ResultSrcE, ALUTypeE, ForwardAE, ForwardBE;
  logic [2:0]      FUN3E;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]      RdM;
  logic            RegWriteM, MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [2:0]      FUN3M;

  modport master (
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW, RdE, ALUControlE,
           ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, JumpRE,
           ResultSrcE, ALUTypeE, ForwardAE, ForwardBE, FUN3E,
    input  PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M, RdM,
           RegWriteM, MemWriteM, ResultSrcM, FUN3M
  );

  modport slave (
    input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW, RdE, ALUControlE,
           ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, JumpRE,
           ResultSrcE, ALUTypeE, ForwardAE, ForwardBE, FUN3E,
    output PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M, RdM,
           RegWriteM, MemWriteM, ResultSrcM, FUN3M
  );
endinterface

// File: rtl/ex_mem_stage_alu.sv
// Combinational ALU; the comparison flags are taken against cmp_b so the
// branch unit always compares against the forwarded rs2, never the immediate.
module alu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] cmp_b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);
  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $signed(a) >>> shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_LUI:   result = b;
      ALU_AUIPC: result = pc + imm;
      default:   result = '0;
    endcase
  end

  assign eq  = (a == cmp_b);
  assign lt  = ($signed(a) < $signed(cmp_b));
  assign ltu = (a < cmp_b);
endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution with a
// combinational fetch redirect, and the EX/MEM pipeline register.
module ex_mem_stage
  import rv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit RAW_TGT_JALR = 1'b0
) (
  input logic           clk,
  input logic           reset,
  ex_mem_stage_if.slave bus
);
  logic [XLEN-1:0] src_a, fwd_b, src_b, jalr_sum;
  logic [XLEN-1:0] alu_result_d, alu_result_q;
  logic [XLEN-1:0] write_data_q, pc_plus4_q;
  logic [4:0]      rd_q;
  logic            reg_write_q, mem_write_q;
  logic [1:0]      result_src_q;
  logic [2:0]      fun3_q;
  logic [3:0]      alu_op;
  logic            eq, lt, ltu, cond;

  // Forward from M uses the register itself, so there is no comb loop.
  always_comb begin
    case (bus.ForwardAE)
      FWD_W:   src_a = bus.ResultW;
      FWD_M:   src_a = alu_result_q;
      default: src_a = bus.RD1E;
    endcase
    case (bus.ForwardBE)
      FWD_W:   fwd_b = bus.ResultW;
      FWD_M:   fwd_b = alu_result_q;
      default: fwd_b = bus.RD2E;
    endcase
  end

  assign src_b  = bus.ALUSrcE ? bus.ImmExtE : fwd_b;
  assign alu_op = (bus.ALUTypeE == ALUT_S) ? ALU_ADD : bus.ALUControlE;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (src_a),
    .b      (src_b),
    .cmp_b  (fwd_b),
    .pc     (bus.PCE),
    .imm    (bus.ImmExtE),
    .op     (alu_op),
    .result (alu_result_d),
    .eq     (eq),
    .lt     (lt),
    .ltu    (ltu)
  );

  always_comb begin
    case (bus.FUN3E)
      BR_EQ:   cond = eq;
      BR_NE:   cond = ~eq;
      BR_LT:   cond = lt;
      BR_GE:   cond = ~lt;
      BR_LTU:  cond = ltu;
      BR_GEU:  cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

  assign jalr_sum      = src_a + bus.ImmExtE;
  assign bus.PCSrcE    = (bus.BranchE & cond) | bus.JumpE | bus.JumpRE;
  assign bus.PCTargetE = !bus.JumpRE  ? (bus.PCE + bus.ImmExtE) :
                         RAW_TGT_JALR ? jalr_sum : {jalr_sum[XLEN-1:1], 1'b0};

  // EX -> MEM boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      result_src_q <= '0;
      mem_write_q  <= 1'b0;
      fun3_q       <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= fwd_b;
      pc_plus4_q   <= bus.PCPlus4E;
      rd_q         <= bus.RdE;
      reg_write_q  <= bus.RegWriteE;
      result_src_q <= bus.ResultSrcE;
      mem_write_q  <= bus.MemWriteE;
      fun3_q       <= bus.FUN3E;
    end
  end

  assign bus.ALUResultM = alu_result_q;
  assign bus.WriteDataM = write_data_q;
  assign bus.PCPlus4M   = pc_plus4_q;
  assign bus.RdM        = rd_q;
  assign bus.RegWriteM  = reg_write_q;
  assign bus.ResultSrcM = result_src_q;
  assign bus.MemWriteM  = mem_write_q;
  assign bus.FUN3M      = fun3_q;
endmodule
